// File: rtl/lsu_mem_master.sv
// Load/store master for a word-wide data memory.
// Sub-word stores are done as read-modify-write; loads are extended.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module lsu_mem_master #(
  parameter int MEM_SIZE = 1024,
  localparam int ADDR_W = $clog2(MEM_SIZE)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_we,
  input  logic [2:0]             i_req_funct3,
  input  logic [31:0]            i_req_addr,
  input  logic [`DATA_WIDTH-1:0] i_req_wdata,
  output logic                   o_resp_valid,
  input  logic                   i_resp_ready,
  output logic [`DATA_WIDTH-1:0] o_resp_rdata,
  output logic                   o_resp_misaligned,
  output logic                   o_resp_fault,
  output logic                   o_mem_we,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [`DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [`DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_t;

  state_t state, state_nx;

  logic                   we_q;
  logic [2:0]             f3_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [`DATA_WIDTH-1:0] wdata_q;
  logic [`DATA_WIDTH-1:0] rbuf;
  logic [`DATA_WIDTH-1:0] rdata_q;
  logic                   mis_q;
  logic                   fault_q;

  logic                   acc;
  logic                   mis;
  logic                   f3_bad;
  logic                   fault;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [`DATA_WIDTH-1:0] ld_data;
  logic [`DATA_WIDTH-1:0] merged;
  logic [ADDR_W-1:0]      word_addr;

  assign acc       = i_req_valid & o_req_ready;
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    mis    = 1'b0;
    f3_bad = 1'b0;
    unique case (i_req_funct3)
      3'b000: f3_bad = 1'b0;
      3'b100: f3_bad = i_req_we;
      3'b001: mis    = i_req_addr[0];
      3'b101: begin
        mis    = i_req_addr[0];
        f3_bad = i_req_we;
      end
      3'b010: mis    = |i_req_addr[1:0];
      default: f3_bad = 1'b1;
    endcase
    fault = f3_bad | (i_req_addr >= 32'(MEM_SIZE));
  end

  always_comb begin
    ld_byte = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? i_mem_rdata[31:16]
                        : i_mem_rdata[15:0];
    unique case (f3_q)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {24'b0, ld_byte};
      3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101: ld_data = {16'b0, ld_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  // Untouched lanes come from the word read in READ.
  always_comb begin
    merged = rbuf;
    unique case (f3_q)
      3'b000: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      3'b001: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        o_req_ready = ~i_rst;
        if (i_req_valid)
          state_nx = (mis | fault) ? RESP : READ;
      end
      READ: begin
        o_mem_addr = word_addr;
        state_nx   = we_q ? WRITE : RESP;
      end
      WRITE: begin
        o_mem_addr  = word_addr;
        o_mem_wdata = merged;
        o_mem_we    = ~i_rst;
        state_nx    = RESP;
      end
      RESP: begin
        o_mem_addr   = word_addr;
        o_resp_valid = ~i_rst;
        if (i_resp_ready) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (acc) begin
        we_q    <= i_req_we;
        f3_q    <= i_req_funct3;
        addr_q  <= i_req_addr[ADDR_W-1:0];
        wdata_q <= i_req_wdata;
        rdata_q <= '0;
        mis_q   <= mis;
        fault_q <= fault;
      end
      if (state == READ) begin
        rbuf <= i_mem_rdata;
        if (!we_q) rdata_q <= ld_data;
      end
    end
  end

  assign o_resp_rdata      = rdata_q;
  assign o_resp_misaligned = mis_q;
  assign o_resp_fault      = fault_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master against a byte-addressed
// reference memory model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_lsu_mem_master;

  localparam int MEM_SIZE = 1024;
  localparam int NW = MEM_SIZE / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_mis;
  logic        resp_fault;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_SIZE(MEM_SIZE)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_we(req_we),
    .i_req_funct3(req_f3),
    .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid),
    .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata),
    .o_resp_misaligned(resp_mis),
    .o_resp_fault(resp_fault),
    .o_mem_we(mem_we),
    .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [31:0] mem [NW];
  logic [7:0]  ref_mem [MEM_SIZE];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          exp_we = 0;
  int          bp = 0;
  bit          seen = 0;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: asynchronous read, synchronous write.
  initial begin
    for (int i = 0; i < NW; i++) begin
      mem[i] = $urandom;
      for (int b = 0; b < 4; b++)
        ref_mem[4*i+b] = mem[i][8*b +: 8];
    end
    mem[4] = 32'h8899AABB;
    for (int b = 0; b < 4; b++)
      ref_mem[16+b] = mem[4][8*b +: 8];
    forever begin
      @(posedge clk);
      if (mem_we) begin
        mem[mem_addr[9:2]] = mem_wdata;
        we_cnt = we_cnt + 1;
      end
    end
  end

  task automatic model(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       output exp_t e);
    int size;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.fault = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
              (we && (f3 == 3'd4 || f3 == 3'd5)) ||
              (addr >= 32'(MEM_SIZE));
    e.mis = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) ||
            ((f3 == 3'd2) && (addr % 4 != 0));
    e.rdata = 32'h0;
    e.acc = 0;
    if (e.fault || e.mis) begin
      e.lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++)
        ref_mem[addr+i] = wdata[8*i +: 8];
      exp_we = exp_we + 1;
      e.lat = 3;
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++)
        v[8*i +: 8] = ref_mem[addr+i];
      if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      e.rdata = v;
      e.lat = 2;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr,
                       input logic [31:0] wdata);
    exp_t e;
    int n;
    @(negedge clk);
    req_we = we;
    req_f3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL req_timeout addr=%h ready=%b want 1",
               addr, req_ready);
      req_valid = 1'b0;
    end else begin
      model(we, f3, addr, wdata, e);
      e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: compares every valid cycle against the queue head.
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_ready = 1'b0;
        seen = 1'b0;
      end else if (resp_valid) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_resp rdata=%h want no response",
                   resp_rdata);
          resp_ready = 1'b1;
        end else begin
          me = q[0];
          if (!seen) begin
            checks++;
            if (cyc - me.acc + 1 != me.lat) begin
              fails++;
              $display("FAIL latency got=%0d want=%0d",
                       cyc - me.acc + 1, me.lat);
            end
            seen = 1'b1;
          end
          checks++;
          if (resp_rdata !== me.rdata || resp_mis !== me.mis ||
              resp_fault !== me.fault) begin
            fails++;
            $display("FAIL resp got=%h/%b/%b want=%h/%b/%b",
                     resp_rdata, resp_mis, resp_fault,
                     me.rdata, me.mis, me.fault);
          end
          checks++;
          if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_in_resp got=%b want 0", req_ready);
          end
          if (bp > 0) begin
            resp_ready = 1'b0;
            bp--;
          end else begin
            resp_ready = ($urandom_range(0, 3) != 0);
          end
          if (resp_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        resp_ready = $urandom_range(0, 1) == 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [2:0] f3tab [8];
  int         base;
  int         n;
  int         bad;

  initial begin
    f3tab[0] = 3'd0; f3tab[1] = 3'd1; f3tab[2] = 3'd2;
    f3tab[3] = 3'd4; f3tab[4] = 3'd5; f3tab[5] = 3'd2;
    f3tab[6] = 3'd0; f3tab[7] = 3'd1;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_f3 = 3'd0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_flags", {30'b0, resp_mis, resp_fault}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'h1);
    chk("idle_mem_addr", 32'(mem_addr), 32'h0);

    issue(1'b0, 3'd0, 32'h11, 32'h0);
    issue(1'b0, 3'd4, 32'h11, 32'h0);
    issue(1'b0, 3'd1, 32'h12, 32'h0);
    issue(1'b0, 3'd5, 32'h12, 32'h0);
    issue(1'b1, 3'd0, 32'h12, 32'h55);
    drain();
    chk("sb_word", mem[4], 32'h8855AABB);
    issue(1'b1, 3'd1, 32'h12, 32'h1234);
    drain();
    chk("sh_word", mem[4], 32'h1234AABB);
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    drain();
    chk("sw_word", mem[4], 32'hDEADBEEF);
    base = we_cnt;
    issue(1'b0, 3'd1, 32'h13, 32'h0);
    issue(1'b1, 3'd2, 32'h12, 32'h01020304);
    issue(1'b0, 3'd3, 32'h10, 32'h0);
    issue(1'b0, 3'd2, 32'(MEM_SIZE), 32'h0);
    issue(1'b1, 3'd4, 32'h10, 32'hFF);
    issue(1'b0, 3'd1, 32'(MEM_SIZE) + 32'd1, 32'h0);
    drain();
    chk("err_no_write", 32'(we_cnt - base), 32'h0);
    chk("err_word", mem[4], 32'hDEADBEEF);
    bp = 3;
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    drain();

    // Reset while the store sits in WRITE.
    base = we_cnt;
    @(negedge clk);
    req_we = 1'b1;
    req_f3 = 3'd2;
    req_addr = 32'h20;
    req_wdata = 32'h12345678;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_store_in_write", 32'(mem_we), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_valid", 32'(resp_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_ready", 32'(req_ready), 32'h1);
    chk("rst_abort_we", 32'(we_cnt - base), 32'h0);
    chk("rst_abort_word",
        mem[8], {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]});
    repeat (3) @(negedge clk);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      logic [2:0]  f;
      int          r;
      r = $urandom_range(0, 19);
      if (r == 0)      a = 32'(MEM_SIZE) + $urandom_range(0, 4000);
      else if (r == 1) a = $urandom | 32'h80000000;
      else             a = $urandom_range(0, MEM_SIZE - 1);
      r = $urandom_range(0, 9);
      f = (r < 8) ? f3tab[r] : 3'($urandom);
      issue($urandom_range(0, 1) == 1, f, a, $urandom);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    drain();

    chk("we_count", 32'(we_cnt), 32'(exp_we));
    bad = 0;
    for (int i = 0; i < NW; i++)
      if (mem[i] !== {ref_mem[4*i+3], ref_mem[4*i+2],
                      ref_mem[4*i+1], ref_mem[4*i]})
        bad++;
    chk("mem_final_mismatch_words", 32'(bad), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
